sys_ctrl: RTL and testbench

Command sequencer between the UART receive path and the system datapath. It parses byte frames delivered by the synchronised RX data path and drives register-file writes and reads plus ALU operations. It returns read data and ALU results as bytes into the TX FIFO, which feeds the UART transmitter. It also drives the ALU clock-gate enable so the ALU clock runs only while an operation is in flight.

---
 rtl/sys_ctrl_if.sv | 51 +++++
 rtl/sys_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the command sequencer and its environment: RX byte stream,
// register file, ALU and TX FIFO. The master side is the sequencer.
interface sys_ctrl_if #(
   parameter int DW     = 8,
   parameter int ADDR_W = 4,
   parameter int ALU_W  = 16
);
   // RX path
   logic [DW-1:0]     RX_P_DATA;
   logic              RX_D_VLD;

   // register file
   logic [DW-1:0]     RdData;
   logic              RdData_Valid;
   logic              WrEn;
   logic              RdEn;
   logic [ADDR_W-1:0] Address;
   logic [DW-1:0]     WrData;

   // ALU
   logic [ALU_W-1:0]  ALU_OUT;
   logic              ALU_OUT_VLD;
   logic              ALU_EN;
   logic [3:0]        ALU_FUN;
   logic              CLK_GATE_EN;

   // TX FIFO
   logic              FIFO_FULL;
   logic [DW-1:0]     TX_P_DATA;
   logic              TX_D_VLD;

   modport master (
      input  RX_P_DATA, RX_D_VLD,
      input  RdData, RdData_Valid,
      input  ALU_OUT, ALU_OUT_VLD,
      input  FIFO_FULL,
      output WrEn, RdEn, Address, WrData,
      output ALU_EN, ALU_FUN, CLK_GATE_EN,
      output TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD,
      output RdData, RdData_Valid,
      output ALU_OUT, ALU_OUT_VLD,
      output FIFO_FULL,
      input  WrEn, RdEn, Address, WrData,
      input  ALU_EN, ALU_FUN, CLK_GATE_EN,
      input  TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/sys_ctrl.sv
// Command sequencer: parses RX byte frames into register-file writes/reads and ALU
// operations, returning results to the TX FIFO. Define CMD_TIMEOUT_EN for a partial-frame timeout.
module sys_ctrl #(
   parameter int DW          = 8,
   parameter int ADDR_W      = 4,
   parameter int ALU_W       = 16,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic       CLK,
   input  logic       RST,
   sys_ctrl_if.master bus
);

   localparam logic [DW-1:0] CMD_WR      = DW'(8'hAA);
   localparam logic [DW-1:0] CMD_RD      = DW'(8'hBB);
   localparam logic [DW-1:0] CMD_ALU_OP  = DW'(8'hCC);
   localparam logic [DW-1:0] CMD_ALU_NOP = DW'(8'hDD);

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      RD_SEND,
      ALU_A,
      ALU_B,
      ALU_FN,
      ALU_WAIT,
      SEND_LO,
      SEND_HI
   } state_t;

   state_t state;
   state_t state_next;

   logic              rx_vld;
   logic [DW-1:0]     rx_byte;
   logic              timeout;

   // registered strobes and register-file bus
   logic              wr_en_q;
   logic              rd_en_q;
   logic              alu_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DW-1:0]     wr_data_q;
   logic [3:0]        alu_fun_q;

   logic              wr_en_d;
   logic              rd_en_d;
   logic              alu_en_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DW-1:0]     wr_data_d;
   logic [3:0]        alu_fun_d;

   // response data captured from the register file and ALU
   logic [DW-1:0]     rd_byte;
   logic [ALU_W-1:0]  alu_res;

   logic              tx_vld;
   logic [DW-1:0]     tx_data;
   logic              gate_en;

   assign rx_vld  = bus.RX_D_VLD;
   assign rx_byte = bus.RX_P_DATA;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (rx_vld) begin
                  case (rx_byte)
                     CMD_WR:      state_next = WR_ADDR;
                     CMD_RD:      state_next = RD_ADDR;
                     CMD_ALU_OP:  state_next = ALU_A;
                     CMD_ALU_NOP: state_next = ALU_FN;
                     default:     state_next = IDLE;
                  endcase
               end
            end
            WR_ADDR:  if (rx_vld) state_next = WR_DATA;
            WR_DATA:  if (rx_vld) state_next = IDLE;
            RD_ADDR:  if (rx_vld) state_next = RD_WAIT;
            RD_WAIT:  if (bus.RdData_Valid) state_next = RD_SEND;
            RD_SEND:  if (!bus.FIFO_FULL) state_next = IDLE;
            ALU_A:    if (rx_vld) state_next = ALU_B;
            ALU_B:    if (rx_vld) state_next = ALU_FN;
            ALU_FN:   if (rx_vld) state_next = ALU_WAIT;
            ALU_WAIT: if (bus.ALU_OUT_VLD) state_next = SEND_LO;
            SEND_LO:  if (!bus.FIFO_FULL) state_next = SEND_HI;
            SEND_HI:  if (!bus.FIFO_FULL) state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   // Register-file/ALU strobes are issued one cycle after the byte that triggers them;
   // TX and clock-gate outputs follow the current state directly.
   always_comb begin
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      alu_fun_d = alu_fun_q;
      tx_vld    = 1'b0;
      tx_data   = '0;
      gate_en   = 1'b0;

      case (state)
         WR_ADDR: begin
            if (rx_vld) addr_d = rx_byte[ADDR_W-1:0];
         end
         WR_DATA: begin
            if (rx_vld) begin
               wr_en_d   = 1'b1;
               wr_data_d = rx_byte;
            end
         end
         RD_ADDR: begin
            if (rx_vld) begin
               rd_en_d = 1'b1;
               addr_d  = rx_byte[ADDR_W-1:0];
            end
         end
         ALU_A: begin
            if (rx_vld) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDR_W'(0);
               wr_data_d = rx_byte;
            end
         end
         ALU_B: begin
            if (rx_vld) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDR_W'(1);
               wr_data_d = rx_byte;
            end
         end
         ALU_FN: begin
            if (rx_vld) begin
               alu_en_d  = 1'b1;
               alu_fun_d = rx_byte[3:0];
            end
         end
         ALU_WAIT: begin
            gate_en = 1'b1;
         end
         RD_SEND: begin
            tx_data = rd_byte;
            tx_vld  = !bus.FIFO_FULL;
         end
         SEND_LO: begin
            tx_data = alu_res[DW-1:0];
            tx_vld  = !bus.FIFO_FULL;
         end
         SEND_HI: begin
            tx_data = alu_res[2*DW-1:DW];
            tx_vld  = !bus.FIFO_FULL;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
         rd_byte   <= '0;
         alu_res   <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         alu_en_q  <= alu_en_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         alu_fun_q <= alu_fun_d;
         if (state == RD_WAIT && bus.RdData_Valid) begin
            rd_byte <= bus.RdData;
         end
         if (state == ALU_WAIT && bus.ALU_OUT_VLD) begin
            alu_res <= bus.ALU_OUT;
         end
      end
   end

`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] idle_cnt;
   logic             timed;

   // Only frame-collecting states are timed; wait and send states depend on the datapath.
   assign timed   = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                    (state == ALU_A)   || (state == ALU_B)   || (state == ALU_FN);
   assign timeout = timed && !rx_vld && (idle_cnt == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         idle_cnt <= '0;
      end else if (rx_vld || !timed || timeout) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign bus.WrEn        = wr_en_q;
   assign bus.RdEn        = rd_en_q;
   assign bus.Address     = addr_q;
   assign bus.WrData      = wr_data_q;
   assign bus.ALU_EN      = alu_en_q;
   assign bus.ALU_FUN     = alu_fun_q;
   assign bus.CLK_GATE_EN = gate_en;
   assign bus.TX_P_DATA   = tx_data;
   assign bus.TX_D_VLD    = tx_vld;

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: directed frames from the test plan followed by random
// frames, scored against frame-level expectation queues and an environment register file.
module tb_sys_ctrl;
   localparam int DW          = 8;
   localparam int ADDR_W      = 4;
   localparam int ALU_W       = 16;
   localparam int TIMEOUT_CYC = 1023;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   sys_ctrl_if #(.DW(DW), .ADDR_W(ADDR_W), .ALU_W(ALU_W)) bus ();

   sys_ctrl #(
      .DW(DW), .ADDR_W(ADDR_W), .ALU_W(ALU_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   // expectations derived from the frames sent
   wr_t        exp_wr[$];
   logic [3:0] exp_rd[$];
   logic [3:0] exp_alu[$];
   logic [7:0] exp_tx[$];

   logic [7:0] model_mem [16];
   logic [7:0] env_mem   [16];
   bit         gate_exp = 1'b0;

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                  bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD});
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      tick();
      bus.RX_D_VLD  = 1'b0;
      bus.RX_P_DATA = 8'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_tx.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("tx_left",  32'(exp_tx.size()),  0);
      check("wr_left",  32'(exp_wr.size()),  0);
      check("rd_left",  32'(exp_rd.size()),  0);
      check("alu_left", 32'(exp_alu.size()), 0);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      exp_wr.push_back('{addr: a, data: d});
      model_mem[a] = d;
      send_byte(8'hAA); gap();
      send_byte({4'($urandom), a}); gap();
      send_byte(d);
      drain();
   endtask

   task automatic do_read(input logic [3:0] a, input int stall, input bit inject);
      exp_rd.push_back(a);
      exp_tx.push_back(model_mem[a]);
      send_byte(8'hBB); gap();
      send_byte({4'($urandom), a});
      repeat ($urandom_range(1, 3)) tick();
      if (inject) send_byte(8'hAA);
      bus.RdData       = env_mem[bus.Address];
      bus.RdData_Valid = 1'b1;
      bus.FIFO_FULL    = (stall != 0);
      tick();
      bus.RdData_Valid = 1'b0;
      bus.RdData       = 8'($urandom);
      if (stall == 0) begin
         @(negedge CLK);
         check("rd_latency", 32'(bus.TX_D_VLD), 1);
      end else begin
         repeat (stall) tick();
         bus.FIFO_FULL = 1'b0;
         @(negedge CLK);
         check("rd_after_stall", 32'(bus.TX_D_VLD), 1);
      end
      drain();
   endtask

   task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fun, input logic [15:0] res,
                         input int stall, input bit inject);
      if (with_ops) begin
         exp_wr.push_back('{addr: 4'd0, data: a});
         exp_wr.push_back('{addr: 4'd1, data: b});
         model_mem[0] = a;
         model_mem[1] = b;
         send_byte(8'hCC); gap();
         send_byte(a); gap();
         send_byte(b); gap();
      end else begin
         send_byte(8'hDD); gap();
      end
      exp_alu.push_back(fun);
      exp_tx.push_back(res[7:0]);
      exp_tx.push_back(res[15:8]);
      send_byte({4'($urandom), fun});
      gate_exp = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
      if (inject) send_byte(8'hBB);
      bus.ALU_OUT     = res;
      bus.ALU_OUT_VLD = 1'b1;
      bus.FIFO_FULL   = (stall != 0);
      tick();
      bus.ALU_OUT_VLD = 1'b0;
      bus.ALU_OUT     = 16'($urandom);
      gate_exp        = 1'b0;
      if (stall != 0) begin
         repeat (stall) tick();
         bus.FIFO_FULL = 1'b0;
      end
      @(negedge CLK);
      check("alu_tx_lo", {23'd0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'd0, 1'b1, res[7:0]});
      tick();
      @(negedge CLK);
      check("alu_tx_hi", {23'd0, bus.TX_D_VLD, bus.TX_P_DATA}, {23'd0, 1'b1, res[15:8]});
      drain();
   endtask

   // Scoreboard: every strobe seen must match the oldest outstanding expectation.
   always @(negedge CLK) begin : monitor
      wr_t w;
      if (RST) begin
         check("tx_while_full", 32'(bus.TX_D_VLD & bus.FIFO_FULL), 0);
         check("clk_gate_en", 32'(bus.CLK_GATE_EN), 32'(gate_exp));
         if (bus.WrEn) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(bus.Address), 32'(w.addr));
               check("wr_data", 32'(bus.WrData), 32'(w.data));
            end
            env_mem[bus.Address] = bus.WrData;
         end
         if (bus.RdEn) begin
            check("rd_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) check("rd_addr", 32'(bus.Address), 32'(exp_rd.pop_front()));
         end
         if (bus.ALU_EN) begin
            check("alu_expected", 32'(exp_alu.size() != 0), 1);
            if (exp_alu.size() != 0) check("alu_fun", 32'(bus.ALU_FUN), 32'(exp_alu.pop_front()));
         end
         if (bus.TX_D_VLD) begin
            check("tx_expected", 32'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) check("tx_data", 32'(bus.TX_P_DATA), 32'(exp_tx.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.RX_P_DATA    = '0;
      bus.RX_D_VLD     = 1'b0;
      bus.RdData       = '0;
      bus.RdData_Valid = 1'b0;
      bus.ALU_OUT      = '0;
      bus.ALU_OUT_VLD  = 1'b0;
      bus.FIFO_FULL    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 8'($urandom);
         env_mem[i]   = model_mem[i];
      end

      repeat (3) tick();
      @(negedge CLK);
      check("reset_outputs", outs(), 0);
      tick();
      RST = 1'b1;
      repeat (2) tick();
      @(negedge CLK);
      check("idle_outputs", outs(), 0);
      tick();

      // write, stalled read-back, ALU with operands
      do_write(4'd5, 8'h3C);
      do_read(4'd5, 10, 1'b0);
      do_alu(1'b1, 8'h12, 8'h34, 4'd2, 16'h1234, 0, 1'b0);

      // unknown command then ALU without operands
      send_byte(8'h55);
      drain();
      do_alu(1'b0, 8'h00, 8'h00, 4'd7, 16'($urandom), 0, 1'b0);

      // bytes arriving during wait states are dropped
      do_read(4'd3, 0, 1'b1);
      do_alu(1'b0, 8'h00, 8'h00, 4'd9, 16'($urandom), 3, 1'b1);

      // asynchronous reset in the middle of a write frame
      send_byte(8'hAA);
      send_byte(8'h05);
      #2;
      RST = 1'b0;
      #1;
      check("rst_async_outputs", outs(), 0);
      repeat (2) tick();
      RST = 1'b1;
      tick();
      do_write(4'd1, 8'hFF);

      // long silence inside a partial write frame
      send_byte(8'hAA);
      send_byte(8'h05);
      repeat (TIMEOUT_CYC + 5) tick();
`ifdef CMD_TIMEOUT_EN
      send_byte(8'h3C);
      drain();
`else
      exp_wr.push_back('{addr: 4'd5, data: 8'h3C});
      model_mem[5] = 8'h3C;
      send_byte(8'h3C);
      drain();
`endif
      do_read(4'd5, 0, 1'b0);

      // random frames
      for (int f = 0; f < 60; f++) begin
         int kind;
         int stall;
         bit inject;
         kind   = $urandom_range(0, 4);
         stall  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
         inject = ($urandom_range(0, 3) == 0);
         case (kind)
            0: do_write(4'($urandom), 8'($urandom));
            1: do_read(4'($urandom), stall, inject);
            2: do_alu(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), stall, inject);
            3: do_alu(1'b0, 8'h00, 8'h00, 4'($urandom), 16'($urandom), stall, inject);
            default: begin
               logic [7:0] junk;
               junk = 8'($urandom_range(0, 8'hA9));
               send_byte(junk);
               drain();
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
